// File: rtl/ffa_pkg.sv
// Shared types and default widths for the FFA initiator.
package ffa_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_N = 8;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/ffa_initiator.sv
// Single-outstanding request initiator for a small synchronous array,
// with an optional zero-fill sweep after reset and a saturating error counter.
module ffa_initiator
  import ffa_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_N  = DEF_DATA_N,
  parameter int INIT_EN = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy,
  output logic                 arr_wr,
  output logic                 arr_rd,
  output logic [ADDR_W-1:0]    arr_addr,
  output logic [DATA_W-1:0]    arr_din,
  input  logic [DATA_W-1:0]    arr_dout,
  input  logic                 arr_error
);

  // One extra bit so DATA_N == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DATA_N_V   = (ADDR_W+1)'(DATA_N);
  localparam logic [ADDR_W:0] SWEEP_LAST = (ADDR_W+1)'(DATA_N - 1);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_ONE = ERR_CNT_W'(1);

  state_t state, next_state;

  logic [ADDR_W:0]   init_cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              in_range;

  assign in_range = ({1'b0, op_addr} < DATA_N_V);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= (INIT_EN != 0) ? INIT : IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      INIT:    if (init_cnt == SWEEP_LAST) next_state = IDLE;
      IDLE:    if (req_valid)              next_state = ISSUE;
      ISSUE:                               next_state = RESP;
      RESP:    if (resp_ready)             next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  // Strobes are gated by resetn so the array sees nothing while reset is held.
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    arr_wr    = 1'b0;
    arr_rd    = 1'b0;
    arr_addr  = '0;
    arr_din   = '0;
    if (resetn) begin
      case (state)
        INIT: begin
          arr_wr   = 1'b1;
          arr_addr = init_cnt[ADDR_W-1:0];
        end
        ISSUE: begin
          if (in_range) begin
            arr_wr   = op_wr;
            arr_rd   = !op_wr;
            arr_addr = op_addr;
            arr_din  = op_wr ? op_wdata : '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      init_cnt   <= '0;
      op_wr      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (state == INIT) begin
        init_cnt <= init_cnt + CNT_ONE;
      end
      if (req_valid && req_ready) begin
        op_wr    <= req_wr;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
      end
      if (state == ISSUE) begin
        resp_valid <= 1'b1;
        resp_rdata <= (!op_wr && in_range) ? arr_dout : '0;
        resp_err   <= arr_error | !in_range;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
        resp_rdata <= '0;
        resp_err   <= 1'b0;
        if (resp_err && (err_cnt != ERR_MAX)) begin
          err_cnt <= err_cnt + ERR_ONE;
        end
      end
    end
  end

endmodule
